// File: rtl/winograd_pkg.sv
// Shared Winograd tile types and dimensions, common to the normalization stage
// and the tile serializer.
package winograd_pkg;

  localparam int WG_TILE_ROWS = 8;
  localparam int WG_TILE_COLS = 10;
  localparam int WG_DATA_W    = 16;

  typedef logic [WG_DATA_W-1:0] wg_tile_t [WG_TILE_ROWS][WG_TILE_COLS];

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_e;

endpackage

// File: rtl/wg_rc_counter.sv
// Row-major row/column index counter with clear, enable and wrap-around.
// It wraps from the last element straight back to [0][0].
module wg_rc_counter #(
  parameter int ROWS = 8,
  parameter int COLS = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  output logic [$clog2(ROWS)-1:0] o_row,
  output logic [$clog2(COLS)-1:0] o_col,
  output logic                    o_last
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  // Clear has priority so a new tile always starts at [0][0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (r_col != COL_MAX) begin
        r_col <= r_col + 1'b1;
      end else begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = (r_row == ROW_MAX) && (r_col == COL_MAX);

endmodule

// File: rtl/winograd_tile_serializer.sv
// Captures a normalized Winograd output tile in one cycle and streams it
// row-major, one element per handshake, accepting the next tile back-to-back.
module winograd_tile_serializer
  import winograd_pkg::*;
#(
  parameter int ROWS   = WG_TILE_ROWS,
  parameter int COLS   = WG_TILE_COLS,
  parameter int DATA_W = WG_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tile_valid,
  output logic                    tile_ready,
  input  logic [DATA_W-1:0]       tile_data [ROWS][COLS],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [$clog2(ROWS)-1:0] out_row,
  output logic [$clog2(COLS)-1:0] out_col,
  output logic                    out_last,
  output logic                    busy
);

  ser_state_e r_state;
  ser_state_e w_state_next;

  logic [DATA_W-1:0]       r_hold [ROWS][COLS];
  logic [$clog2(ROWS)-1:0] w_row;
  logic [$clog2(COLS)-1:0] w_col;
  logic                    w_cnt_last;
  logic                    w_tile_hs;
  logic                    w_elem_hs;

  assign w_tile_hs = tile_valid && tile_ready;
  assign w_elem_hs = out_valid && out_ready;

  wg_rc_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_rc_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_tile_hs),
    .i_en   (w_elem_hs),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_last (w_cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Holding register is deliberately left unreset; it is only ever read in STREAM.
  always_ff @(posedge clk) begin
    if (w_tile_hs) begin
      r_hold <= tile_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    tile_ready   = 1'b0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_row      = '0;
    out_col      = '0;
    out_last     = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        tile_ready = 1'b1;
        if (tile_valid) begin
          w_state_next = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = r_hold[w_row][w_col];
        out_row   = w_row;
        out_col   = w_col;
        out_last  = w_cnt_last;
        // A new tile may only land as the last element leaves, keeping the stream gapless.
        tile_ready = w_cnt_last && out_ready;
        if (w_cnt_last && out_ready && !tile_valid) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_winograd_tile_serializer.sv
// Self-checking bench: control vector tables plus a scoreboard of expected
// elements queued at each tile handshake and compared on each element handshake.
module tb_winograd_tile_serializer;
  import winograd_pkg::*;

  localparam int ROWS = WG_TILE_ROWS;
  localparam int COLS = WG_TILE_COLS;
  localparam int DW   = WG_DATA_W;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tile_valid = 1'b0;
  logic           tile_ready;
  wg_tile_t       tile_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [DW-1:0]  out_data;
  logic [2:0]     out_row;
  logic [3:0]     out_col;
  logic           out_last;
  logic           busy;

  always #10 clk = ~clk;

  winograd_tile_serializer #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tile_valid (tile_valid),
    .tile_ready (tile_ready),
    .tile_data  (tile_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    row;
    logic [3:0]    col;
    logic          last;
  } elem_t;

  typedef struct packed {
    logic tv;
    logic ordy;
    logic e_tr;
    logic e_ov;
    logic e_last;
    logic e_busy;
  } vec_t;

  elem_t exp_q[$];
  vec_t  vecs [8];

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    acc_cyc  = 0;
  int    last_cyc = 0;
  int    n_valid  = 0;
  int    n_last   = 0;
  int    n_stall  = 0;
  int    a1       = 0;
  logic  acc      = 1'b0;
  logic  prev_stall = 1'b0;
  elem_t prev_elem;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic checkv(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic load_tile(input logic [DW-1:0] base);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        tile_data[r][c] = base + DW'(r * 16 + c);
  endtask

  // One clock: sample at the falling edge, score handshakes, return at posedge+1.
  task automatic cycle();
    elem_t cur;
    elem_t e;
    @(negedge clk);
    cyc++;
    acc = tile_valid && tile_ready;
    cur = {out_data, out_row, out_col, out_last};
    if (prev_stall) checkv("stall_hold", 32'({out_valid, cur}), 32'({1'b1, prev_elem}));
    if (out_valid) n_valid++;
    if (out_valid && !out_ready) n_stall++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check1("elem_expected", 1'b0, 1'b1);
      end else begin
        e = exp_q.pop_front();
        checkv("elem", 32'(cur), 32'(e));
      end
      if (out_last) begin
        n_last++;
        last_cyc = cyc;
        $display("cycle %0d: tile completed, last data 0x%0h", cyc, out_data);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_elem  = cur;
    if (acc) begin
      acc_cyc = cyc;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          exp_q.push_back({tile_data[r][c], 3'(r), 4'(c), (r == ROWS - 1) && (c == COLS - 1)});
      $display("cycle %0d: tile accepted, first data 0x%0h", cyc, tile_data[0][0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int budget);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!acc && k < budget);
    check1("accept_seen", acc, 1'b1);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      cycle();
      k++;
    end
    checkv("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  // Combinational vectors applied within one clock phase, away from any edge.
  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      tile_valid = vecs[i].tv;
      out_ready  = vecs[i].ordy;
      #1;
      check1($sformatf("vec%0d_tile_ready", i), tile_ready, vecs[i].e_tr);
      check1($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check1($sformatf("vec%0d_out_last", i), out_last, vecs[i].e_last);
      check1($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // {tile_valid, out_ready, tile_ready, out_valid, out_last, busy}
    vecs[0] = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // IDLE
    vecs[1] = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};  // STREAM, last element
    vecs[5] = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6] = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[7] = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    load_tile(16'h0000);
    #5;
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_out_last", out_last, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_tile_ready", tile_ready, 1'b1);
    checkv("rst_out_data", 32'(out_data), 32'd0);
    checkv("rst_out_rc", 32'({out_row, out_col}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle after reset
    apply_vecs(0, 3);
    tile_valid = 1'b0;
    out_ready  = 1'b0;
    repeat (20) begin
      cycle();
      check1("idle_tile_ready", tile_ready, 1'b1);
      check1("idle_out_valid", out_valid, 1'b0);
      check1("idle_busy", busy, 1'b0);
    end

    // Single tile, no backpressure
    n_last = 0;
    load_tile(16'h0000);
    tile_valid = 1'b1;
    out_ready  = 1'b1;
    wait_accept(5);
    tile_valid = 1'b0;
    a1 = acc_cyc;
    check1("lat_out_valid", out_valid, 1'b1);
    checkv("lat_first", 32'({out_data, out_row, out_col}), 32'd0);
    drain(200);
    checkv("single_drain_cycles", 32'(last_cyc - a1), 32'd80);
    checkv("single_n_last", 32'(n_last), 32'd1);
    cycle();
    check1("single_idle_valid", out_valid, 1'b0);
    check1("single_idle_busy", busy, 1'b0);
    check1("single_idle_ready", tile_ready, 1'b1);

    // Back-to-back tiles
    n_valid = 0;
    n_last  = 0;
    load_tile(16'h0000);
    tile_valid = 1'b1;
    out_ready  = 1'b1;
    wait_accept(5);
    a1 = acc_cyc;
    load_tile(16'h0100);
    wait_accept(100);
    tile_valid = 1'b0;
    checkv("b2b_second_accept", 32'(acc_cyc - a1), 32'd80);
    checkv("b2b_accept_on_last", 32'(acc_cyc), 32'(last_cyc));
    drain(200);
    checkv("b2b_valid_cycles", 32'(n_valid), 32'd160);
    checkv("b2b_n_last", 32'(n_last), 32'd2);
    checkv("b2b_span", 32'(last_cyc - a1), 32'd160);

    // Random backpressure, upstream data changes after the handshake
    cycle();
    n_stall = 0;
    load_tile(16'h0000);
    tile_valid = 1'b1;
    out_ready  = 1'b1;
    wait_accept(5);
    a1 = acc_cyc;
    tile_valid = 1'b0;
    load_tile(16'hBEE0);
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      k++;
    end
    checkv("bp_drain_done", 32'(exp_q.size()), 32'd0);
    checkv("bp_cycles", 32'(last_cyc - a1), 32'(80 + n_stall));

    // Stall on the last element with a tile waiting
    out_ready = 1'b1;
    load_tile(16'h0300);
    tile_valid = 1'b1;
    wait_accept(5);
    tile_valid = 1'b0;
    load_tile(16'h0400);
    k = 0;
    while (!out_last && k < 100) begin
      cycle();
      k++;
    end
    out_ready = 1'b0;
    check1("reach_last", out_last, 1'b1);
    apply_vecs(4, 7);
    tile_valid = 1'b1;
    out_ready  = 1'b0;
    repeat (3) begin
      cycle();
      check1("stall_last_ready", tile_ready, 1'b0);
      check1("stall_last_flag", out_last, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check1("stall_release_ready", tile_ready, 1'b1);
    cycle();
    check1("stall_release_accept", acc, 1'b1);
    tile_valid = 1'b0;
    drain(200);

    // Reset in the middle of a tile
    load_tile(16'h0500);
    tile_valid = 1'b1;
    out_ready  = 1'b1;
    wait_accept(5);
    tile_valid = 1'b0;
    k = 0;
    while (!(out_row == 3'd3 && out_col == 4'd5) && k < 100) begin
      cycle();
      k++;
    end
    checkv("mid_reach_3_5", 32'({out_row, out_col}), 32'({3'd3, 4'd5}));
    #2;
    rst_n = 1'b0;
    #1;
    check1("mid_rst_valid", out_valid, 1'b0);
    check1("mid_rst_last", out_last, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    exp_q.delete();
    prev_stall = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    check1("post_rst_ready", tile_ready, 1'b1);
    check1("post_rst_valid", out_valid, 1'b0);
    load_tile(16'h0600);
    tile_valid = 1'b1;
    wait_accept(5);
    tile_valid = 1'b0;
    checkv("post_rst_first", 32'({out_data, out_row, out_col}), 32'({16'h0600, 3'd0, 4'd0}));
    drain(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
